// File: rtl/pkt_frame_arbiter.sv
// Two-requester whole-packet arbiter with round-robin fairness,
// max-length truncation and stray-beat draining while idle.
module pkt_frame_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_head,
  input  logic              req0_tail,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_head,
  input  logic              req1_tail,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic              out_head,
  output logic              out_tail,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        gnt,
  output logic              abort,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    XFER0,
    XFER1
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_BEATS - 1);

  state_t            state;
  state_t            state_nx;
  logic              last_gnt;
  logic              last_gnt_nx;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nx;
  logic              cand0;
  logic              cand1;
  logic              win0;
  logic              win1;
  logic              stray0;
  logic              stray1;
  logic              fwd;
  logic              fwd_head;
  logic              fwd_tail;
  logic [DATA_W-1:0] fwd_data;
  logic              trunc;
  logic [CNT_W:0]    drop_sum;

  assign cand0 = req0_valid & req0_head;
  assign cand1 = req1_valid & req1_head;
  assign gnt   = {state == XFER1, state == XFER0};

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    cnt_nx      = cnt;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    win0        = 1'b0;
    win1        = 1'b0;
    stray0      = 1'b0;
    stray1      = 1'b0;
    fwd         = 1'b0;
    fwd_head    = 1'b0;
    fwd_tail    = 1'b0;
    fwd_data    = '0;
    trunc       = 1'b0;
    unique case (state)
      IDLE: begin
        // last_gnt holds the previous winner; the other side wins a tie
        win0       = cand0 & (~cand1 | last_gnt);
        win1       = cand1 & (~cand0 | ~last_gnt);
        stray0     = req0_valid & ~req0_head;
        stray1     = req1_valid & ~req1_head;
        req0_ready = win0 | stray0;
        req1_ready = win1 | stray1;
        if (win0) begin
          fwd         = 1'b1;
          fwd_head    = 1'b1;
          fwd_tail    = req0_tail;
          fwd_data    = req0_data;
          last_gnt_nx = 1'b0;
          cnt_nx      = 8'd1;
          if (!req0_tail) state_nx = XFER0;
        end else if (win1) begin
          fwd         = 1'b1;
          fwd_head    = 1'b1;
          fwd_tail    = req1_tail;
          fwd_data    = req1_data;
          last_gnt_nx = 1'b1;
          cnt_nx      = 8'd1;
          if (!req1_tail) state_nx = XFER1;
        end
      end
      XFER0: begin
        req0_ready = 1'b1;
        if (req0_valid) begin
          fwd      = 1'b1;
          fwd_data = req0_data;
          trunc    = ~req0_tail & (cnt == LAST);
          fwd_tail = req0_tail | trunc;
          cnt_nx   = cnt + 8'd1;
          if (fwd_tail) state_nx = IDLE;
        end
      end
      XFER1: begin
        req1_ready = 1'b1;
        if (req1_valid) begin
          fwd      = 1'b1;
          fwd_data = req1_data;
          trunc    = ~req1_tail & (cnt == LAST);
          fwd_tail = req1_tail | trunc;
          cnt_nx   = cnt + 8'd1;
          if (fwd_tail) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign drop_sum = {1'b0, drop_cnt}
                  + {{CNT_W{1'b0}}, stray0}
                  + {{CNT_W{1'b0}}, stray1};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_head  <= 1'b0;
      out_tail  <= 1'b0;
      out_data  <= '0;
      abort     <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      last_gnt  <= last_gnt_nx;
      cnt       <= cnt_nx;
      out_valid <= fwd;
      out_head  <= fwd_head;
      out_tail  <= fwd_tail;
      out_data  <= fwd_data;
      abort     <= trunc;
      drop_cnt  <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pkt_frame_arbiter.sv
// Directed bench for pkt_frame_arbiter (MAX_BEATS=4, CNT_W=8).
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_pkt_frame_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req0_head, req0_tail, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_head, req1_tail, req1_ready;
  logic [7:0] req1_data;
  logic       out_valid, out_head, out_tail, abort;
  logic [7:0] out_data;
  logic [1:0] gnt;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pkt_frame_arbiter #(
    .DATA_W(8), .MAX_BEATS(4), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_head(req0_head),
    .req0_tail(req0_tail), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_head(req1_head),
    .req1_tail(req1_tail), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .out_valid(out_valid), .out_head(out_head),
    .out_tail(out_tail), .out_data(out_data),
    .gnt(gnt), .abort(abort), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic v, h, t, input logic [7:0] d);
    req0_valid = v; req0_head = h; req0_tail = t; req0_data = d;
  endtask

  task automatic drv1(input logic v, h, t, input logic [7:0] d);
    req1_valid = v; req1_head = h; req1_tail = t; req1_data = d;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic rdy(input string tag, input logic r0, r1);
    #1;
    check({tag, ".rdy0"}, 32'(req0_ready), 32'(r0));
    check({tag, ".rdy1"}, 32'(req1_ready), 32'(r1));
  endtask

  task automatic outp(input string tag, input logic v, h, t,
                      input logic [7:0] d, input logic [1:0] g);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    if (v) begin
      check({tag, ".head"}, 32'(out_head), 32'(h));
      check({tag, ".tail"}, 32'(out_tail), 32'(t));
      check({tag, ".data"}, 32'(out_data), 32'(d));
    end
  endtask

  initial begin
    reset = 1'b0;
    drv0(1, 1, 0, 8'h11);
    drv1(1, 1, 0, 8'h22);
    rdy("rst", 0, 0);
    repeat (3) tick();
    outp("rst", 0, 0, 0, 8'h00, 2'b00);
    check("rst.abort", 32'(abort), 0);
    check("rst.drop", 32'(drop_cnt), 0);
    rdy("rst2", 0, 0);

    // single requester, 3-beat packet
    reset = 1'b1;
    drv1(0, 0, 0, 8'h00);
    drv0(1, 1, 0, 8'hA1);
    rdy("a1", 1, 0);
    tick();
    outp("a1", 1, 1, 0, 8'hA1, 2'b01);
    drv0(1, 0, 0, 8'hA2);
    rdy("a2", 1, 0);
    tick();
    outp("a2", 1, 0, 0, 8'hA2, 2'b01);
    drv0(1, 0, 1, 8'hA3);
    tick();
    outp("a3", 1, 0, 1, 8'hA3, 2'b00);
    drv0(0, 0, 0, 8'h00);
    tick();
    outp("a_gap", 0, 0, 0, 8'h00, 2'b00);

    // contention straight after reset: req0 first
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drv0(1, 1, 0, 8'hB1);
    drv1(1, 1, 0, 8'hC1);
    rdy("c_b1", 1, 0);
    tick();
    outp("c_b1", 1, 1, 0, 8'hB1, 2'b01);
    drv0(1, 0, 1, 8'hB2);
    rdy("c_b2", 1, 0);
    tick();
    outp("c_b2", 1, 0, 1, 8'hB2, 2'b00);
    drv0(0, 0, 0, 8'h00);
    rdy("c_c1", 0, 1);
    tick();
    outp("c_c1", 1, 1, 0, 8'hC1, 2'b10);
    drv1(1, 0, 1, 8'hC2);
    tick();
    outp("c_c2", 1, 0, 1, 8'hC2, 2'b00);
    drv0(1, 1, 0, 8'hD1);
    drv1(1, 1, 0, 8'hE1);
    rdy("c_d1", 1, 0);
    tick();
    outp("c_d1", 1, 1, 0, 8'hD1, 2'b01);
    drv0(1, 0, 1, 8'hD2);
    tick();
    outp("c_d2", 1, 0, 1, 8'hD2, 2'b00);
    drv0(0, 0, 0, 8'h00);
    tick();
    outp("c_e1", 1, 1, 0, 8'hE1, 2'b10);
    drv1(1, 0, 1, 8'hE2);
    tick();
    outp("c_e2", 1, 0, 1, 8'hE2, 2'b00);

    // truncation: 6 beats from req1, MAX_BEATS=4
    drv1(1, 1, 0, 8'hF1);
    rdy("t_f1", 0, 1);
    tick();
    outp("t_f1", 1, 1, 0, 8'hF1, 2'b10);
    drv1(1, 0, 0, 8'hF2);
    tick();
    outp("t_f2", 1, 0, 0, 8'hF2, 2'b10);
    drv1(1, 1, 0, 8'hF3);
    tick();
    outp("t_f3", 1, 0, 0, 8'hF3, 2'b10);
    check("t_f3.abort", 32'(abort), 0);
    drv1(1, 0, 0, 8'hF4);
    tick();
    outp("t_f4", 1, 0, 1, 8'hF4, 2'b00);
    check("t_f4.abort", 32'(abort), 1);
    drv1(1, 0, 0, 8'hF5);
    rdy("t_f5", 0, 1);
    tick();
    outp("t_f5", 0, 0, 0, 8'h00, 2'b00);
    check("t_f5.abort", 32'(abort), 0);
    drv1(1, 0, 1, 8'hF6);
    tick();
    check("t_drop", 32'(drop_cnt), 2);
    drv1(0, 0, 0, 8'h00);

    // single-beat packet then stray saturation
    drv0(1, 1, 1, 8'h5A);
    tick();
    outp("s_5a", 1, 1, 1, 8'h5A, 2'b00);
    drv0(1, 0, 0, 8'h77);
    for (int i = 0; i < 252; i++) tick();
    check("s_drop254", 32'(drop_cnt), 254);
    check("s_out", 32'(out_valid), 0);
    drv1(1, 0, 0, 8'h66);
    rdy("s_dual", 1, 1);
    tick();
    check("s_dual_sat", 32'(drop_cnt), 255);
    drv1(0, 0, 0, 8'h00);
    for (int i = 0; i < 47; i++) tick();
    check("s_drop_sat", 32'(drop_cnt), 255);
    drv0(0, 0, 0, 8'h00);

    // reset in the middle of a packet
    drv0(1, 1, 0, 8'h31);
    tick();
    outp("m_g1", 1, 1, 0, 8'h31, 2'b01);
    drv0(1, 0, 0, 8'h32);
    tick();
    outp("m_g2", 1, 0, 0, 8'h32, 2'b01);
    drv0(1, 0, 0, 8'h33);
    reset = 1'b0;
    rdy("m_rst", 0, 0);
    tick();
    outp("m_rst", 0, 0, 0, 8'h00, 2'b00);
    check("m_rst.abort", 32'(abort), 0);
    check("m_rst.drop", 32'(drop_cnt), 0);
    reset = 1'b1;
    drv0(1, 1, 0, 8'h41);
    drv1(1, 1, 0, 8'h42);
    rdy("m_tie", 1, 0);
    tick();
    outp("m_tie", 1, 1, 0, 8'h41, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_frame_arbiter.md
Name: pkt_frame_arbiter

Overview:
- Two-requester packet arbiter. Each requester presents head/tail/valid-framed beats, the same framing the fsm packet tracker monitors.
- Grants the shared output channel for whole packets (head through tail) with round-robin fairness.
- Enforces a maximum packet length and drains stray non-head beats seen while idle.
- Sits between two packet sources and the single downstream framing checker/consumer.

Parameters:
- DATA_W, 8, width of beat payload
- MAX_BEATS, 16, maximum beats per packet including head; range 2..255
- CNT_W, 8, width of the drop counter

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low
- req0_valid  input  1  requester 0 beat valid
- req0_head  input  1  requester 0 beat is first of packet
- req0_tail  input  1  requester 0 beat is last of packet
- req0_data  input  DATA_W  requester 0 payload
- req0_ready  output  1  requester 0 beat accepted this cycle (combinational)
- req1_valid, req1_head, req1_tail, req1_data, req1_ready  same as requester 0
- out_valid  output  1  registered forwarded beat valid
- out_head  output  1  registered head flag
- out_tail  output  1  registered tail flag
- out_data  output  DATA_W  registered payload
- gnt  output  2  one-hot owner of the channel; 00 when idle
- abort  output  1  one-cycle pulse: packet truncated at MAX_BEATS
- drop_cnt  output  CNT_W  saturating count of stray beats drained while idle

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, gnt=00, all out_* = 0, abort=0, drop_cnt=0, beat count=0, last_gnt=1 (requester 0 wins first tie).
- A reset asserted mid-packet takes effect at the next edge. The packet in flight is abandoned: no tail and no abort is emitted.
- States: IDLE, XFER0, XFER1.
- Beat transfer occurs when reqN_valid & reqN_ready. A transferred beat appears on out_* exactly 1 cycle later (registered). out_valid=0 in any cycle following no transfer.
- IDLE arbitration:
  - candidates are requesters with valid & head
  - one candidate: it wins
  - both: the requester != last_gnt wins
  - the winner's reqN_ready=1 in the same cycle, and its head beat is transferred
  - next state XFERN, gnt=one-hot(N), last_gnt=N, beat count=1
- Single-beat packet (head & tail on the accepted head beat): forwarded with out_head=out_tail=1; state stays IDLE, gnt stays 00.
- Stray beat in IDLE (valid & !head, with no candidate on that requester): reqN_ready=1, beat drained, not forwarded. drop_cnt increments, saturating at all-ones; two strays in one cycle add 2, still saturating. A stray on one requester is drained even while the other requester wins.
- XFERN:
  - reqN_ready=1; the other requester's ready=0 and it must hold its beat
  - each transferred beat is forwarded and the count increments
  - head=1 on a mid-packet beat is stripped (out_head=0)
  - tail beat: forwarded with out_tail=1; next state IDLE, gnt=00
  - beat with count==MAX_BEATS-1 and no tail (the MAX_BEATS-th beat): forwarded with out_tail forced 1, abort=1 with the same timing as out_tail; next state IDLE. Later non-head beats from that requester count as strays.
- Back-to-back packets: a new head may be accepted in the cycle after the tail is accepted (IDLE cycle). Minimum one-cycle gap between packets from any source. Round-robin applies at every IDLE decision.
- No backpressure from downstream; out_* is always consumed.

Test Plan:
- Reset: drive reset=0 for 3 cycles with both requesters presenting heads -> gnt=00, out_valid=0, drop_cnt=0, both ready=0.
- Single requester: req0 sends a 3-beat packet, data A1,A2,A3 -> out beats A1(head),A2,A3(tail) each 1 cycle after acceptance; gnt=01 through the beat after A1 up to A3's output cycle, then 00.
- Contention: both present heads in the same IDLE cycle after reset, 2-beat packets each -> req0 packet fully forwarded first. req1 held (ready=0) until req0 tail, wins the next IDLE cycle, and its packet follows. A repeat contention then grants req0 again (alternation).
- Truncation: MAX_BEATS=4; req1 sends 6 beats with tail on beat 6 -> beat 4 out with out_tail=1 and abort=1 for one cycle. Beats 5 and 6 drained as strays, drop_cnt=2.
- Single-beat and strays: req0 head&tail beat 0x5A -> out_head=out_tail=1, data 0x5A, gnt stays 00. Then 300 stray beats on req0 with CNT_W=8 -> drop_cnt saturates at 255.
- Mid-packet reset: reset=0 after 2 of 5 beats of req0 -> next cycle gnt=00, out_valid=0. The next head from req0 arbitrates normally, and req0 wins a tie (last_gnt reset to 1).
